prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
// PURPOSE
//   Parametrised N-to-log2(N) priority encoder with a registered output, a valid/ready
//   handshake on both sides and a selectable fixed- or round-robin-priority mode.
//   Next-generation replacement for the 4:2 combinational encoder. Sits between
//   request sources (interrupt lines, channel requests) and a downstream consumer
//   that may stall.
// PARAMETERS
//   N        8   number of request inputs; N >= 2 and N must be a power of two
//   RR_MODE  0   0 = fixed priority, highest index wins; 1 = round-robin rotating priority
//   W        derived, $clog2(N); localparam, never overridden
// PORTS
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   req        in   N  request vector, sampled on the accept cycle
//   in_valid   in   1  req is valid this cycle
//   in_ready   out  1  block can accept req this cycle
//   out_valid  out  1  out_* fields hold a result
//   out_ready  in   1  consumer takes the result this cycle
//   out_idx    out  W  encoded index of the winning request
//   out_onehot out  N  one-hot copy of the winner (all zero when out_none = 1)
//   out_none   out  1  the accepted req was all zero
// BEHAVIOUR
//   - Reset: on rising clk with rst = 1, all of the following clear:
//     out_valid = 0, out_idx = 0, out_onehot = 0, out_none = 0, RR pointer ptr = 0.
//     rst has priority over every other event. A pending result is dropped.
//   - Handshake:
//     in_ready = !out_valid || out_ready (combinational, no bubble).
//     Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
//   - Latency: exactly 1 cycle. Results from the accepted req appear on the next edge
//     with out_valid = 1.
//   - Stall: while out_valid && !out_ready, all out_* hold stable and no accept occurs.
//   - Simultaneous events:
//     - pop and accept in the same cycle: the new result replaces the old; out_valid stays 1.
//     - pop with no accept: out_valid -> 0 and out_* hold their last values.
//   - Fixed mode: winner = highest set index. Example: req = 8'b0010_0110 -> idx 5.
//   - RR mode: search from ptr upward, wrapping N-1 -> 0. The first set bit wins.
//     On each accept with a non-zero req, ptr <= (idx + 1) mod N. Wrap occurs naturally
//     at W bits. ptr is unchanged by a zero req and by stalls. In fixed mode ptr is
//     unused and stays at 0.
//   - Zero request: the result is still produced, with out_none = 1, out_idx = 0 and
//     out_onehot = 0.
//   - out_onehot == (1 << out_idx) whenever out_valid && !out_none.
// STRUCTURE
//   - Package enc_pkg:
//     - function clog2;
//     - localparam PRIO_FIXED = 0, PRIO_RR = 1;
//     - typedef for the result record {idx, onehot, none}.
//   - One sub-module, prio_find: combinational. Inputs are req and start pointer.
//     Outputs are idx, onehot and none. The rotate, search and unrotate are implemented
//     inside it. Fixed mode instantiates it with start = 0 and a reversed search
//     direction, selected by parameter.
//   - Top level: handshake logic, output register and ptr register.
// TESTING
//   - Reset: hold rst 3 cycles with in_valid = 1, req = 8'hFF ->
//     out_valid = 0, in_ready = 1, out_* = 0.
//   - Fixed, N = 8, out_ready = 1: req = 8'h01, 8'h02, 8'h86 on consecutive cycles ->
//     idx 0, 1, 7 one cycle later each; onehot 01, 02, 80.
//   - Zero request: req = 8'h00 -> out_valid = 1, out_none = 1, idx = 0, onehot = 0;
//     in RR mode ptr is unchanged.
//   - RR, N = 8: req = 8'hFF for 10 accepts -> idx 0, 1, ..., 7, 0, 1 (wrap).
//     Then req = 8'h11 twice -> idx 4, 0.
//   - Stall: out_ready = 0 for 4 cycles after one accept -> in_ready = 0 and
//     out_* stable. Raise out_ready with a new req = 8'h40 -> pop and accept in the same
//     cycle; next idx = 6; out_valid never drops.
//   - Reset mid-operation: assert rst while out_valid = 1 and ptr = 5 ->
//     next cycle out_valid = 0; first RR accept of 8'hFF gives idx 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants, the result record and a width helper for the priority encoder.
package enc_pkg;

    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

    // Result record is sized for the largest supported N; narrower instances zero-extend.
    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 6;

    typedef struct packed {
        logic             none;
        logic [MAX_W-1:0] idx;
        logic [MAX_N-1:0] onehot;
    } enc_result_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle between a request source and the priority encoder.
interface prio_encoder_rr_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = enc_pkg::clog2(N);

    logic [N-1:0] req;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_none;

    modport master (
        output req, in_valid, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_none
    );

    modport slave (
        input  req, in_valid, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_none
    );

endinterface

// File: rtl/prio_find.sv
// Combinational search for the first set request starting at a pointer, with wrap-around.
module prio_find #(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = 3,
    parameter bit          DESCEND = 1'b0
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         none
);

    logic [N-1:0] rot;
    logic [W-1:0] pos;

    // Rotate so that bit 0 of rot is req[start]; index arithmetic wraps at W bits.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = req[W'(i) + start];
        end
    end

    // Last match in loop order wins, so iterate away from the preferred end.
    always_comb begin
        pos = '0;
        if (DESCEND) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (rot[i]) pos = W'(i);
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (rot[i]) pos = W'(i);
            end
        end
    end

    assign none   = ~|req;
    assign idx    = none ? '0 : pos + start;
    assign onehot = none ? '0 : (N'(1) << idx);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N:log2(N) priority encoder with valid/ready on both sides, fixed or round-robin.
module prio_encoder_rr
    import enc_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned RR_MODE = PRIO_FIXED
) (
    input logic              clk,
    input logic              rst,
    prio_encoder_rr_if.slave bus
);

    localparam int unsigned W = clog2(N);

    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    enc_result_t  res_q, res_d;

    logic [W-1:0] start;
    logic [W-1:0] find_idx;
    logic [N-1:0] find_onehot;
    logic         find_none;
    logic         accept;
    logic         pop;

    assign start = (RR_MODE == PRIO_RR) ? ptr_q : '0;

    prio_find #(
        .N       (N),
        .W       (W),
        .DESCEND (RR_MODE == PRIO_FIXED)
    ) u_find (
        .req    (bus.req),
        .start  (start),
        .idx    (find_idx),
        .onehot (find_onehot),
        .none   (find_none)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = valid_q && bus.out_ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d      = 1'b1;
            res_d.none   = find_none;
            res_d.idx    = MAX_W'(find_idx);
            res_d.onehot = MAX_N'(find_onehot);
            if (RR_MODE == PRIO_RR && !find_none) begin
                ptr_d = find_idx + W'(1);
            end
        end else if (pop) begin
            // Fields hold their last values after a pop.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = res_q.idx[W-1:0];
    assign bus.out_onehot = res_q.onehot[N-1:0];
    assign bus.out_none   = res_q.none;

    // Upper record bits stay zero for N < MAX_N.
    logic unused_res;
    assign unused_res = ^{res_q.idx, res_q.onehot};

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed and round-robin instances, directed tables plus random.
module tb_prio_encoder_rr;
    import enc_pkg::*;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prio_encoder_rr_if #(.N(N)) bus_f ();
    prio_encoder_rr_if #(.N(N)) bus_r ();

    prio_encoder_rr #(.N(N), .RR_MODE(PRIO_FIXED)) u_fix (.clk(clk), .rst(rst), .bus(bus_f));
    prio_encoder_rr #(.N(N), .RR_MODE(PRIO_RR))    u_rr  (.clk(clk), .rst(rst), .bus(bus_r));

    int tests = 0;
    int fails = 0;

    // Reference state: index 0 = fixed instance, 1 = round-robin instance.
    bit           m_valid  [2];
    logic [W-1:0] m_idx    [2];
    logic [N-1:0] m_onehot [2];
    bit           m_none   [2];
    int           m_ptr    [2];

    typedef struct {
        bit           rr;
        logic [N-1:0] req;
        logic [W-1:0] idx;
        logic [N-1:0] onehot;
        logic         none;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // First set bit scanning from ptr upward (rr) or from the top down (fixed); -1 if none.
    function automatic int ref_winner(input logic [N-1:0] r, input int ptr, input bit rr);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = rr ? (ptr + k) % int'(N) : int'(N) - 1 - k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] rq [2];
        bit           iv [2];
        bit           ordy [2];
        rq[0] = bus_f.req; iv[0] = bus_f.in_valid; ordy[0] = bus_f.out_ready;
        rq[1] = bus_r.req; iv[1] = bus_r.in_valid; ordy[1] = bus_r.out_ready;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] = 1'b0; m_idx[d] = '0; m_onehot[d] = '0;
                m_none[d] = 1'b0; m_ptr[d] = 0;
            end else if (iv[d] && (!m_valid[d] || ordy[d])) begin
                int w;
                w = ref_winner(rq[d], m_ptr[d], d == 1);
                m_valid[d]  = 1'b1;
                m_none[d]   = (w < 0);
                m_idx[d]    = (w < 0) ? '0 : W'(w);
                m_onehot[d] = (w < 0) ? '0 : N'(1) << w;
                if (d == 1 && w >= 0) m_ptr[d] = (w + 1) % int'(N);
            end else if (m_valid[d] && ordy[d]) begin
                m_valid[d] = 1'b0;
            end
        end
    endtask

    task automatic check_both();
        cmp("fix.out_valid",  32'(bus_f.out_valid),  32'(m_valid[0]));
        cmp("fix.in_ready",   32'(bus_f.in_ready),   32'(!m_valid[0] || bus_f.out_ready));
        cmp("fix.out_idx",    32'(bus_f.out_idx),    32'(m_idx[0]));
        cmp("fix.out_onehot", 32'(bus_f.out_onehot), 32'(m_onehot[0]));
        cmp("fix.out_none",   32'(bus_f.out_none),   32'(m_none[0]));
        cmp("rr.out_valid",   32'(bus_r.out_valid),  32'(m_valid[1]));
        cmp("rr.in_ready",    32'(bus_r.in_ready),   32'(!m_valid[1] || bus_r.out_ready));
        cmp("rr.out_idx",     32'(bus_r.out_idx),    32'(m_idx[1]));
        cmp("rr.out_onehot",  32'(bus_r.out_onehot), 32'(m_onehot[1]));
        cmp("rr.out_none",    32'(bus_r.out_none),   32'(m_none[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_both();
    endtask

    task automatic check_rr(input string tag, input bit v, input logic [W-1:0] i,
                            input logic [N-1:0] oh, input bit nn);
        cmp({tag, ".out_valid"},  32'(bus_r.out_valid),  32'(v));
        cmp({tag, ".out_idx"},    32'(bus_r.out_idx),    32'(i));
        cmp({tag, ".out_onehot"}, 32'(bus_r.out_onehot), 32'(oh));
        cmp({tag, ".out_none"},   32'(bus_r.out_none),   32'(nn));
    endtask

    initial begin
        bus_f.req = 8'hFF; bus_f.in_valid = 1'b1; bus_f.out_ready = 1'b1;
        bus_r.req = 8'hFF; bus_r.in_valid = 1'b1; bus_r.out_ready = 1'b1;
        rst = 1'b1;

        // Reset held for three cycles with requests pending.
        repeat (3) tick();
        cmp("rst.fix.out_valid",  32'(bus_f.out_valid),  32'd0);
        cmp("rst.fix.in_ready",   32'(bus_f.in_ready),   32'd1);
        cmp("rst.fix.out_idx",    32'(bus_f.out_idx),    32'd0);
        cmp("rst.fix.out_onehot", 32'(bus_f.out_onehot), 32'd0);
        cmp("rst.fix.out_none",   32'(bus_f.out_none),   32'd0);
        check_rr("rst.rr", 1'b0, 3'd0, 8'h00, 1'b0);
        cmp("rst.rr.in_ready",    32'(bus_r.in_ready),   32'd1);
        rst = 1'b0;
        bus_f.in_valid = 1'b0;
        bus_r.in_valid = 1'b0;

        vecs.push_back('{1'b0, 8'h01, 3'd0, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 8'h02, 3'd1, 8'h02, 1'b0});
        vecs.push_back('{1'b0, 8'h86, 3'd7, 8'h80, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 3'd0, 8'h00, 1'b1});
        for (int k = 0; k < 10; k++) begin
            vecs.push_back('{1'b1, 8'hFF, W'(k % 8), N'(1) << (k % 8), 1'b0});
        end
        vecs.push_back('{1'b1, 8'h11, 3'd4, 8'h10, 1'b0});
        vecs.push_back('{1'b1, 8'h11, 3'd0, 8'h01, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 3'd0, 8'h00, 1'b1});
        // Pointer must still be 1 after the zero request.
        vecs.push_back('{1'b1, 8'h03, 3'd1, 8'h02, 1'b0});

        foreach (vecs[v]) begin
            if (vecs[v].rr) begin
                bus_f.in_valid = 1'b0;
                bus_r.req = vecs[v].req; bus_r.in_valid = 1'b1;
            end else begin
                bus_r.in_valid = 1'b0;
                bus_f.req = vecs[v].req; bus_f.in_valid = 1'b1;
            end
            tick();
            if (vecs[v].rr) begin
                check_rr($sformatf("vec%0d", v), 1'b1, vecs[v].idx, vecs[v].onehot,
                         vecs[v].none);
            end else begin
                cmp($sformatf("vec%0d.out_valid", v),  32'(bus_f.out_valid),  32'd1);
                cmp($sformatf("vec%0d.out_idx", v),    32'(bus_f.out_idx),    32'(vecs[v].idx));
                cmp($sformatf("vec%0d.out_onehot", v), 32'(bus_f.out_onehot),
                    32'(vecs[v].onehot));
                cmp($sformatf("vec%0d.out_none", v),   32'(bus_f.out_none),   32'(vecs[v].none));
            end
        end
        bus_f.in_valid = 1'b0;
        bus_r.in_valid = 1'b0;
        tick();

        // Stall: one accept (ptr 2 -> idx 2), then four cycles of back-pressure.
        bus_r.req = 8'h0C; bus_r.in_valid = 1'b1; bus_r.out_ready = 1'b0;
        tick();
        check_rr("stall.first", 1'b1, 3'd2, 8'h04, 1'b0);
        bus_r.req = 8'hF0;
        for (int c = 0; c < 4; c++) begin
            tick();
            cmp($sformatf("stall%0d.in_ready", c), 32'(bus_r.in_ready), 32'd0);
            check_rr($sformatf("stall%0d", c), 1'b1, 3'd2, 8'h04, 1'b0);
        end
        bus_r.out_ready = 1'b1; bus_r.req = 8'h40;
        #1;
        cmp("release.in_ready", 32'(bus_r.in_ready), 32'd1);
        tick();
        check_rr("release", 1'b1, 3'd6, 8'h40, 1'b0);

        // Pop with no accept: valid drops, fields hold.
        bus_r.in_valid = 1'b0;
        tick();
        check_rr("pop_only", 1'b0, 3'd6, 8'h40, 1'b0);

        // Reset mid-operation with ptr at 5 and a result pending.
        bus_r.req = 8'h10; bus_r.in_valid = 1'b1; bus_r.out_ready = 1'b0;
        tick();
        check_rr("pre_rst", 1'b1, 3'd4, 8'h10, 1'b0);
        bus_r.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_rr("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
        bus_r.req = 8'hFF; bus_r.in_valid = 1'b1; bus_r.out_ready = 1'b1;
        tick();
        check_rr("post_rst", 1'b1, 3'd0, 8'h01, 1'b0);

        // Random traffic on both instances against the reference model.
        for (int c = 0; c < 400; c++) begin
            bus_f.req       = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            bus_f.in_valid  = ($urandom_range(0, 3) != 0);
            bus_f.out_ready = ($urandom_range(0, 9) < 7);
            bus_r.req       = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            bus_r.in_valid  = ($urandom_range(0, 3) != 0);
            bus_r.out_ready = ($urandom_range(0, 9) < 7);
            rst             = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
